// File: rtl/iq_hard_demod_if.sv
// I/Q sample-in / nibble-out bus for the hard-decision demodulator.
interface iq_hard_demod_if;
   logic [1:0] mod_sel;
   logic       in_valid;
   logic [3:0] i_in;
   logic [3:0] q_in;
   logic       align;
   logic [3:0] data_out;
   logic       data_valid;
   logic       sym_err;

   modport master (
      output mod_sel, in_valid, i_in, q_in, align,
      input  data_out, data_valid, sym_err
   );

   modport slave (
      input  mod_sel, in_valid, i_in, q_in, align,
      output data_out, data_valid, sym_err
   );
endinterface

// File: rtl/iq_hard_demod.sv
// Integrate-and-dump I/Q receiver: hard-slices BPSK/QPSK/16-QAM symbols and packs
// the recovered bits MSB first into 4-bit nibbles.
module iq_hard_demod #(
   parameter int unsigned SPS     = 4,
   parameter int unsigned QAM_THR = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   iq_hard_demod_if.slave  bus
);

   localparam int unsigned AW  = 4 + $clog2(SPS) + 1;
   localparam int unsigned CW  = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int          THR = int'(QAM_THR * SPS);

   typedef enum logic [1:0] {
      MODE_BPSK  = 2'b00,
      MODE_QPSK  = 2'b01,
      MODE_QAM16 = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   mode_e                mode_q, mode_d;
   logic signed [AW-1:0] acc_i_q, acc_i_d;
   logic signed [AW-1:0] acc_q_q, acc_q_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           bit_cnt_q, bit_cnt_d;
   logic [2:0]           sr_q, sr_d;
   logic [3:0]           data_out_q, data_out_d;
   logic                 data_valid_q, data_valid_d;
   logic                 sym_err_q, sym_err_d;

   logic signed [AW-1:0] samp_i, samp_q, base_i, base_q, sum_i, sum_q;
   logic [CW-1:0]        base_cnt;
   logic [1:0]           base_bits;
   int                   sum_i_ext, sum_q_ext;
   logic                 pos_i, pos_q, inner_i, inner_q;
   logic [3:0]           nib;
   logic                 emit;

   // Accumulate, slice on the completing sample and pack into the nibble register.
   always_comb begin
      mode_d       = mode_e'(bus.mod_sel);
      acc_i_d      = acc_i_q;
      acc_q_d      = acc_q_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      sr_d         = sr_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      sym_err_d    = 1'b0;

      samp_i    = AW'($signed(bus.i_in));
      samp_q    = AW'($signed(bus.q_in));
      base_i    = bus.align ? '0 : acc_i_q;
      base_q    = bus.align ? '0 : acc_q_q;
      base_cnt  = bus.align ? '0 : cnt_q;
      base_bits = bus.align ? '0 : bit_cnt_q;
      sum_i     = base_i + samp_i;
      sum_q     = base_q + samp_q;
      sum_i_ext = int'(sum_i);
      sum_q_ext = int'(sum_q);
      pos_i     = (sum_i_ext >= 0);
      pos_q     = (sum_q_ext >= 0);
      inner_i   = (sum_i_ext > -THR) && (sum_i_ext < THR);
      inner_q   = (sum_q_ext > -THR) && (sum_q_ext < THR);
      nib       = 4'b0000;
      emit      = 1'b0;

      if (mode_d != mode_q) begin
         // Mode switch aborts the partial symbol/nibble and drops this cycle's sample.
         acc_i_d   = '0;
         acc_q_d   = '0;
         cnt_d     = '0;
         bit_cnt_d = '0;
      end else begin
         acc_i_d   = base_i;
         acc_q_d   = base_q;
         cnt_d     = base_cnt;
         bit_cnt_d = base_bits;
         if (bus.in_valid) begin
            if (base_cnt == CW'(SPS - 1)) begin
               acc_i_d = '0;
               acc_q_d = '0;
               cnt_d   = '0;
               unique case (mode_q)
                  MODE_BPSK: begin
                     nib       = {sr_q, pos_i};
                     sr_d      = nib[2:0];
                     bit_cnt_d = 2'(base_bits + 2'd1);
                     emit      = (base_bits == 2'd3);
                  end
                  MODE_QPSK: begin
                     nib       = {sr_q[1:0], pos_i, pos_q};
                     sr_d      = nib[2:0];
                     bit_cnt_d = 2'(base_bits + 2'd2);
                     emit      = (base_bits == 2'd2);
                  end
                  MODE_QAM16: begin
                     nib  = {pos_i, inner_i, pos_q, inner_q};
                     emit = 1'b1;
                  end
                  MODE_RSVD: begin
                     sym_err_d = 1'b1;
                  end
                  default: ;
               endcase
               if (emit) begin
                  data_out_d   = nib;
                  data_valid_d = 1'b1;
                  bit_cnt_d    = '0;
               end
            end else begin
               acc_i_d = sum_i;
               acc_q_d = sum_q;
               cnt_d   = CW'(base_cnt + CW'(1));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= MODE_BPSK;
         acc_i_q      <= '0;
         acc_q_q      <= '0;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         sr_q         <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         sym_err_q    <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         acc_i_q      <= acc_i_d;
         acc_q_q      <= acc_q_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_q         <= sr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         sym_err_q    <= sym_err_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.sym_err    = sym_err_q;

endmodule
